alu_exec: RTL and testbench

Execute-stage arithmetic unit of the MIPS pipeline and the consumer of the 5-bit `alucontrol` code produced by the ALU decoder. It performs single-cycle logic/arithmetic/compare operations, holds the architectural HI/LO registers, runs MULT/MULTU in one cycle and DIV/DIVU on an iterative 32-step restoring divider. While a divide runs it asserts `stall` to freeze the front of the pipeline.

---
 rtl/alu_exec.sv | 150 +++++++++++++++
 tb/tb_alu_exec.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: MIPS execute-stage ALU with HI/LO registers, single-cycle multiply
// and an iterative restoring divider that stalls the front of the pipeline.
module alu_exec #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush,
    input  logic [4:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        stall,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [4:0] AND_CONTROL   = 5'd0;
    localparam logic [4:0] OR_CONTROL    = 5'd1;
    localparam logic [4:0] XOR_CONTROL   = 5'd2;
    localparam logic [4:0] NOR_CONTROL   = 5'd3;
    localparam logic [4:0] ADD_CONTROL   = 5'd4;
    localparam logic [4:0] ADDU_CONTROL  = 5'd5;
    localparam logic [4:0] SUB_CONTROL   = 5'd6;
    localparam logic [4:0] SUBU_CONTROL  = 5'd7;
    localparam logic [4:0] SLT_CONTROL   = 5'd8;
    localparam logic [4:0] SLTU_CONTROL  = 5'd9;
    localparam logic [4:0] LUI_CONTROL   = 5'd10;
    localparam logic [4:0] MULT_CONTROL  = 5'd11;
    localparam logic [4:0] MULTU_CONTROL = 5'd12;
    localparam logic [4:0] DIV_CONTROL   = 5'd13;
    localparam logic [4:0] DIVU_CONTROL  = 5'd14;
    localparam logic [4:0] MFHI_CONTROL  = 5'd15;
    localparam logic [4:0] MFLO_CONTROL  = 5'd16;
    localparam logic [4:0] MTHI_CONTROL  = 5'd17;
    localparam logic [4:0] MTLO_CONTROL  = 5'd18;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0] count;
    logic [31:0]   hi, lo, quo, rem, dvs;
    logic          neg_q, neg_r;
    logic [31:0]   sum, dif, abs_a, abs_b, q_fix, r_fix;
    logic [63:0]   ext_a, ext_b, prod;
    logic [32:0]   rem_sh, trial;
    logic          wr_ok, is_div, sgn_div, div_issue, is_mult;

    assign sum       = a + b;
    assign dif       = a - b;
    assign wr_ok     = valid_i & ~flush;
    assign sgn_div   = alucontrol == DIV_CONTROL;
    assign is_div    = sgn_div | (alucontrol == DIVU_CONTROL);
    assign is_mult   = (alucontrol == MULT_CONTROL) | (alucontrol == MULTU_CONTROL);
    assign div_issue = (state == IDLE) & wr_ok & is_div;

    // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    assign ext_a = {{32{(alucontrol == MULT_CONTROL) & a[31]}}, a};
    assign ext_b = {{32{(alucontrol == MULT_CONTROL) & b[31]}}, b};
    assign prod  = ext_a * ext_b;

    assign abs_a  = (sgn_div & a[31]) ? -a : a;
    assign abs_b  = (sgn_div & b[31]) ? -b : b;
    assign rem_sh = {rem, quo[31]};
    assign trial  = rem_sh - {1'b0, dvs};
    assign q_fix  = neg_q ? -quo : quo;
    assign r_fix  = neg_r ? -rem : rem;

    assign hi_o = hi;
    assign lo_o = lo;

    always_comb begin
        result = '0;
        case (alucontrol)
            AND_CONTROL:  result = a & b;
            OR_CONTROL:   result = a | b;
            XOR_CONTROL:  result = a ^ b;
            NOR_CONTROL:  result = ~(a | b);
            ADD_CONTROL,
            ADDU_CONTROL: result = sum;
            SUB_CONTROL,
            SUBU_CONTROL: result = dif;
            SLT_CONTROL:  result = {31'b0, $signed(a) < $signed(b)};
            SLTU_CONTROL: result = {31'b0, a < b};
            LUI_CONTROL:  result = {b[15:0], 16'h0};
            MFHI_CONTROL: result = hi;
            MFLO_CONTROL: result = lo;
            default:      result = '0;
        endcase
    end

    always_comb begin
        overflow = valid_i & (((alucontrol == ADD_CONTROL) & (a[31] == b[31]) & (sum[31] != a[31]))
                            | ((alucontrol == SUB_CONTROL) & (a[31] != b[31]) & (dif[31] != a[31])));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush)                 state_n = IDLE;
        else if (state == IDLE)    state_n = div_issue ? BUSY : IDLE;
        else if (state == BUSY)    state_n = (count == CW'(ITER - 1)) ? DONE : BUSY;
        else                       state_n = IDLE;
    end

    always_comb begin
        stall = ~flush & (div_issue | (state == BUSY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            if (div_issue) begin
                quo   <= abs_a;
                dvs   <= abs_b;
                rem   <= '0;
                count <= '0;
                neg_q <= sgn_div & (a[31] ^ b[31]);
                neg_r <= sgn_div & a[31];
            end else if ((state == BUSY) & ~flush) begin
                // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                quo   <= {quo[30:0], ~trial[32]};
                rem   <= trial[32] ? rem_sh[31:0] : trial[31:0];
                count <= count + 1'b1;
            end
            if ((state == DONE) & ~flush) begin
                hi <= r_fix;
                lo <= q_fix;
            end else if (wr_ok & (state == IDLE)) begin
                if (is_mult) {hi, lo} <= prod;
                if (alucontrol == MTHI_CONTROL) hi <= a;
                if (alucontrol == MTLO_CONTROL) lo <= a;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: self-checking bench for alu_exec; HI/LO results flow through a scoreboard queue.
module tb_alu_exec;
    localparam logic [4:0] C_AND = 5'd0, C_OR = 5'd1, C_XOR = 5'd2, C_NOR = 5'd3;
    localparam logic [4:0] C_ADD = 5'd4, C_ADDU = 5'd5, C_SUB = 5'd6, C_SUBU = 5'd7;
    localparam logic [4:0] C_SLT = 5'd8, C_SLTU = 5'd9, C_LUI = 5'd10;
    localparam logic [4:0] C_MULT = 5'd11, C_MULTU = 5'd12, C_DIV = 5'd13, C_DIVU = 5'd14;
    localparam logic [4:0] C_MFHI = 5'd15, C_MFLO = 5'd16, C_MTHI = 5'd17, C_MTLO = 5'd18;

    logic        clk = 1'b0;
    logic        rst, valid_i, flush, overflow, stall;
    logic [4:0]  alucontrol;
    logic [31:0] a, b, result, hi_o, lo_o;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;
    hl_t sb[$];

    alu_exec #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush(flush),
        .alucontrol(alucontrol), .a(a), .b(b), .result(result),
        .overflow(overflow), .stall(stall), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        valid_i = v;
        alucontrol = op;
        a = x;
        b = y;
        #1;
    endtask

    // Counts consecutive stall cycles starting from the current cycle, bounded.
    task automatic wait_div(output int n);
        n = 0;
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_i = 1'b0; flush = 1'b0; alucontrol = C_AND; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
        checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        drive(1'b1, C_ADD, 32'd3, 32'd4);
        checks++; if (result !== 32'd7) begin errors++; $display("FAIL add_3_4 got=%h exp=7", result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_3_4_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_logic;
        logic [31:0] x, y;
        logic [4:0]  ops[7];
        logic [31:0] exps[7];
        x = 32'hF0F0_1234;
        y = 32'h0FF0_ABCD;
        ops  = '{C_AND, C_OR, C_XOR, C_NOR, C_SUB, C_LUI, 5'd31};
        exps = '{x & y, x | y, x ^ y, ~(x | y), x - y, {y[15:0], 16'h0}, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ops[i], x, y);
            checks++;
            if (result !== exps[i]) begin
                errors++; $display("FAIL logic_op%0d got=%h exp=%h", ops[i], result, exps[i]);
            end
        end
    endtask

    task automatic test_overflow;
        drive(1'b1, C_ADD, 32'h7FFF_FFFF, 32'h1);
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result got=%h exp=80000000", result); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL add_ovf got=%b exp=1", overflow); end
        drive(1'b1, C_ADDU, 32'h7FFF_FFFF, 32'h1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL addu_ovf got=%b exp=0", overflow); end
        drive(1'b0, C_ADD, 32'h7FFF_FFFF, 32'h1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_ovf_invalid got=%b exp=0", overflow); end
        drive(1'b1, C_SUB, 32'h8000_0000, 32'h1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sub_ovf got=%b exp=1", overflow); end
        drive(1'b1, C_SUBU, 32'h8000_0000, 32'h1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL subu_ovf got=%b exp=0", overflow); end
        drive(1'b1, C_SLT, 32'hFFFF_FFFF, 32'h1);
        checks++; if (result !== 32'h1) begin errors++; $display("FAIL slt got=%h exp=1", result); end
        drive(1'b1, C_SLTU, 32'hFFFF_FFFF, 32'h1);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL sltu got=%h exp=0", result); end
    endtask

    task automatic test_multiply;
        hl_t e;
        drive(1'b1, C_MULT, 32'hFFFF_FFFE, 32'd3);
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
        drive(1'b0, C_AND, 32'h0, 32'h0);
        e = sb.pop_front();
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL mult_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL mult_lo got=%h exp=%h", lo_o, e.lo); end
        drive(1'b1, C_MULTU, 32'hFFFF_FFFE, 32'd3);
        sb.push_back('{hi: 32'h2, lo: 32'hFFFF_FFFA});
        drive(1'b1, C_MFHI, 32'h0, 32'h0);
        e = sb.pop_front();
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL multu_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL multu_lo got=%h exp=%h", lo_o, e.lo); end
        checks++; if (result !== e.hi) begin errors++; $display("FAIL mfhi got=%h exp=%h", result, e.hi); end
    endtask

    task automatic test_signed_div;
        hl_t e;
        int  n;
        drive(1'b1, C_DIV, 32'hFFFF_FFF9, 32'd2);
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        wait_div(n);
        checks++; if (n != 33) begin errors++; $display("FAIL div_stall_cycles got=%0d exp=33", n); end
        drive(1'b1, C_MFLO, 32'h0, 32'h0);
        e = sb.pop_front();
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL div_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL div_lo got=%h exp=%h", lo_o, e.lo); end
        checks++; if (result !== e.lo) begin errors++; $display("FAIL mflo_after_div got=%h exp=%h", result, e.lo); end
    endtask

    task automatic test_divzero;
        hl_t e;
        int  n;
        drive(1'b1, C_DIVU, 32'd10, 32'd0);
        sb.push_back('{hi: 32'd10, lo: 32'hFFFF_FFFF});
        wait_div(n);
        checks++; if (n != 33) begin errors++; $display("FAIL divz_stall_cycles got=%0d exp=33", n); end
        drive(1'b0, C_AND, 32'h0, 32'h0);
        e = sb.pop_front();
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL divz_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL divz_lo got=%h exp=%h", lo_o, e.lo); end
    endtask

    task automatic test_flush;
        hl_t         e;
        int          n;
        logic [31:0] lo_before;
        drive(1'b1, C_MTHI, 32'h55, 32'h0);
        drive(1'b0, C_AND, 32'h0, 32'h0);
        checks++; if (hi_o !== 32'h55) begin errors++; $display("FAIL mthi got=%h exp=55", hi_o); end
        lo_before = lo_o;
        drive(1'b1, C_DIV, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        @(negedge clk);
        flush = 1'b0;
        valid_i = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_flush_stall got=%b exp=0", stall); end
        checks++; if (hi_o !== 32'h55) begin errors++; $display("FAIL flush_hi got=%h exp=55", hi_o); end
        checks++; if (lo_o !== lo_before) begin errors++; $display("FAIL flush_lo got=%h exp=%h", lo_o, lo_before); end
        drive(1'b1, C_DIVU, 32'd100, 32'd7);
        sb.push_back('{hi: 32'd2, lo: 32'd14});
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL divu_after_flush_issue got=%b exp=1", stall); end
        wait_div(n);
        checks++; if (n != 33) begin errors++; $display("FAIL divu_after_flush_cycles got=%0d exp=33", n); end
        drive(1'b0, C_AND, 32'h0, 32'h0);
        e = sb.pop_front();
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL divu_100_7_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL divu_100_7_lo got=%h exp=%h", lo_o, e.lo); end
    endtask

    task automatic test_back_to_back;
        hl_t e;
        int  n;
        drive(1'b1, C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        sb.push_back('{hi: 32'h0, lo: 32'h8000_0000});
        wait_div(n);
        checks++; if (n != 33) begin errors++; $display("FAIL b2b_first_cycles got=%0d exp=33", n); end
        drive(1'b1, C_DIVU, 32'hFFFF_FFFF, 32'h10);
        sb.push_back('{hi: 32'hF, lo: 32'h0FFF_FFFF});
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_issue_stall got=%b exp=1", stall); end
        e = sb.pop_front();
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL b2b_first_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL b2b_first_lo got=%h exp=%h", lo_o, e.lo); end
        wait_div(n);
        checks++; if (n != 33) begin errors++; $display("FAIL b2b_second_cycles got=%0d exp=33", n); end
        drive(1'b0, C_AND, 32'h0, 32'h0);
        e = sb.pop_front();
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL b2b_second_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL b2b_second_lo got=%h exp=%h", lo_o, e.lo); end
    endtask

    initial begin
        test_reset;
        test_logic;
        test_overflow;
        test_multiply;
        test_signed_div;
        test_divzero;
        test_flush;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
